// File: rtl/radix4_mult_pkg.sv
// Shared types and helpers for the parametrised radix-4 Booth multiplier.
//   state_t       : controller states (IDLE, CALC)
//   booth_digit_t : encoded Booth digit {neg, two, one}
//   digits_*      : number of Booth digits retired per operation
package radix4_mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } booth_digit_t;

  // Signed operands need exactly WIDTH/2 digits.
  function automatic int digits_signed(input int width);
    return width / 2;
  endfunction

  // Unsigned operands need one extra digit to absorb the zero extension.
  function automatic int digits_unsigned(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/radix4_booth_enc.sv
// Radix-4 Booth encoder.
//   win   : {x[2i+1], x[2i], x[2i-1]} window of the multiplier
//   digit : {neg, two, one}; value = (neg ? -1 : 1) * (two ? 2 : one ? 1 : 0)
module radix4_booth_enc
  import radix4_mult_pkg::*;
(
  input  logic [2:0]   win,
  output booth_digit_t digit
);

  // 111 encodes zero, so neg is suppressed there to avoid a "negative zero".
  assign digit.neg = win[2] & ~(win[1] & win[0]);
  assign digit.one = win[1] ^ win[0];
  assign digit.two = (win == 3'b011) || (win == 3'b100);

endmodule

// File: rtl/radix4_booth_mult_param.sv
// Parametrised radix-4 (modified Booth) sequential multiplier.
// Operands load from the shared bus 'in' via getA/getX level strobes while idle;
// a rising edge of start launches a multiply that retires one Booth digit per clock.
//   clk, rst        : clock, synchronous active-high reset
//   start           : launch request (rising edge only)
//   getA, getX      : operand load strobes (IDLE only)
//   sgn             : 1 = two's-complement operands, 0 = unsigned
//   in              : shared operand bus, WIDTH bits
//   product         : 2*WIDTH result, held until the next accepted start
//   ready           : product valid
//   busy            : high while calculating
module radix4_booth_mult_param
  import radix4_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH / 2 + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               getA,
  input  logic               getX,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   in,
  output logic [2*WIDTH-1:0] product,
  output logic               ready,
  output logic               busy
);

  localparam int AW = 2 * WIDTH + 2;   // accumulator width, two guard bits
  localparam int MW = WIDTH + 3;       // {ext[1:0], X, 1'b0}
  localparam logic [CNT_W-1:0] LAST_S = CNT_W'(digits_signed(WIDTH) - 1);
  localparam logic [CNT_W-1:0] LAST_U = CNT_W'(digits_unsigned(WIDTH) - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("radix4_booth_mult_param: WIDTH must be even and >= 4");
  end

  state_t                state;
  logic [WIDTH-1:0]      a_reg;
  logic [WIDTH-1:0]      x_reg;
  logic [MW-1:0]         mshift;
  logic signed [AW-1:0]  acc;
  logic [CNT_W-1:0]      cnt;
  logic                  mode;
  logic                  start_q;

  booth_digit_t          digit;
  logic signed [AW-1:0]  aext;
  logic signed [AW-1:0]  pp;
  logic signed [AW-1:0]  acc_next;
  logic                  accept;
  logic                  last;

  // digit * multiplicand, modulo 2^AW
  function automatic logic signed [AW-1:0] partial_product(
    input booth_digit_t         d,
    input logic signed [AW-1:0] m
  );
    logic signed [AW-1:0] mag;
    mag = d.two ? (m <<< 1) : (d.one ? m : '0);
    return d.neg ? -mag : mag;
  endfunction

  radix4_booth_enc u_enc (
    .win   (mshift[2:0]),
    .digit (digit)
  );

  assign aext     = {{(AW - WIDTH){a_reg[WIDTH-1] & mode}}, a_reg};
  assign pp       = partial_product(digit, aext);
  assign acc_next = acc + (pp <<< {cnt, 1'b0});
  assign accept   = (state == IDLE) && start && !start_q && !getA && !getX;
  assign last     = (cnt == (mode ? LAST_S : LAST_U));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      x_reg   <= '0;
      mshift  <= '0;
      acc     <= '0;
      cnt     <= '0;
      mode    <= 1'b0;
      start_q <= 1'b0;
      product <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // Tracks start in every state so a start held through completion
      // cannot retrigger.
      start_q <= start;
      case (state)
        IDLE: begin
          if (getA) a_reg <= in;
          if (getX) x_reg <= in;
          if (accept) begin
            acc    <= '0;
            cnt    <= '0;
            mode   <= sgn;
            mshift <= {{2{x_reg[WIDTH-1] & sgn}}, x_reg, 1'b0};
            ready  <= 1'b0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          // Top bit replicates the extension so later windows stay consistent.
          mshift <= {{2{mshift[MW-1]}}, mshift[MW-1:2]};
          cnt    <= cnt + 1'b1;
          if (last) begin
            product <= acc_next[2*WIDTH-1:0];
            ready   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_booth_mult_param.sv
module tb_radix4_booth_mult_param;

  logic        clk = 1'b0;
  logic        rst, start, getA, getX, sgn;
  logic [7:0]  in;
  logic [15:0] product;
  logic        ready, busy;

  logic        start16, getA16, getX16, sgn16;
  logic [15:0] in16;
  logic [31:0] product16;
  logic        ready16, busy16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  radix4_booth_mult_param #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .getA(getA), .getX(getX), .sgn(sgn),
    .in(in), .product(product), .ready(ready), .busy(busy)
  );

  radix4_booth_mult_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .getA(getA16), .getX(getX16), .sgn(sgn16),
    .in(in16), .product(product16), .ready(ready16), .busy(busy16)
  );

  // Reference: plain integer multiplication, truncated to 2*w bits.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] x,
                                        input logic s, input int w);
    longint oa, ox, p;
    if (s) begin
      oa = (w == 8) ? longint'($signed(a[7:0])) : longint'($signed(a));
      ox = (w == 8) ? longint'($signed(x[7:0])) : longint'($signed(x));
    end else begin
      oa = (w == 8) ? longint'(a[7:0]) : longint'(a);
      ox = (w == 8) ? longint'(x[7:0]) : longint'(x);
    end
    p = oa * ox;
    return (w == 8) ? {16'h0, p[15:0]} : p[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] a, input logic [7:0] x);
    getA = 1'b1; in = a; step();
    getA = 1'b0; getX = 1'b1; in = x; step();
    getX = 1'b0;
  endtask

  // Launch a multiply; start held 'hold' cycles; optional getA poke mid-CALC.
  task automatic run8(input string tag, input logic s, input logic [15:0] exp,
                      input int hold, input bit poke);
    int lat, busyc, n;
    n = s ? 4 : 5;
    sgn = s; start = 1'b1;
    step();
    if (hold <= 1) start = 1'b0;
    chk({tag, "_ready_low"}, {31'b0, ready}, 32'd0);
    lat = 0; busyc = 0;
    while (!ready && lat < 40) begin
      if (busy) busyc++;
      if (hold > 1 && lat >= hold - 1) start = 1'b0;
      if (poke && lat == 1) begin getA = 1'b1; in = ~in; end
      else getA = 1'b0;
      step();
      lat++;
    end
    getA = 1'b0;
    chk({tag, "_latency"}, lat, n);
    chk({tag, "_busy_cycles"}, busyc, n);
    chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
    chk({tag, "_product"}, {16'h0, product}, {16'h0, exp});
    for (int k = lat; k < hold - 1; k++) step();
    start = 1'b0;
  endtask

  initial begin
    logic [7:0]  ra, rx;
    logic        rs;
    logic [31:0] e;
    int          lat;

    rst = 1'b1; start = 0; getA = 0; getX = 0; sgn = 0; in = '0;
    start16 = 0; getA16 = 0; getX16 = 0; sgn16 = 0; in16 = '0;
    step(); step();
    chk("reset_product", {16'h0, product}, 32'd0);
    chk("reset_ready", {31'b0, ready}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    step();

    load8(8'hFB, 8'hFF);
    run8("signed_fb_ff", 1'b1, 16'h0005, 1, 1'b0);
    run8("unsigned_fb_ff", 1'b0, 16'hFA05, 1, 1'b0);

    // X reload held 8 cycles, then a start held 6 cycles.
    getX = 1'b1; in = 8'd8;
    for (int k = 0; k < 8; k++) step();
    getX = 1'b0; step();
    chk("ready_held_over_reload", {31'b0, ready}, 32'd1);
    run8("signed_reload_held_start", 1'b1, 16'hFFD8, 6, 1'b0);
    step(); step();
    chk("held_start_no_retrigger_busy", {31'b0, busy}, 32'd0);
    chk("held_start_no_retrigger_ready", {31'b0, ready}, 32'd1);

    load8(8'h80, 8'h80);
    run8("signed_minneg", 1'b1, 16'h4000, 1, 1'b0);
    load8(8'hFF, 8'hFF);
    run8("unsigned_max", 1'b0, 16'hFE01, 1, 1'b0);

    // getA pulse during CALC must not disturb A.
    load8(8'h37, 8'hC5);
    run8("poke_getA", 1'b1, model(16'h37, 16'hC5, 1'b1, 8), 1, 1'b1);
    run8("poke_getA_again", 1'b1, model(16'h37, 16'hC5, 1'b1, 8), 1, 1'b0);

    // Start edge coincident with getX is dropped, but the load happens.
    getX = 1'b1; in = 8'h03; start = 1'b1; sgn = 1'b1;
    step();
    getX = 1'b0; start = 1'b0;
    chk("dropped_start_busy", {31'b0, busy}, 32'd0);
    chk("dropped_start_ready", {31'b0, ready}, 32'd1);
    step();
    chk("dropped_start_still_idle", {31'b0, busy}, 32'd0);
    run8("after_dropped", 1'b1, model(16'h37, 16'h03, 1'b1, 8), 1, 1'b0);

    // Reset mid-CALC.
    load8(8'h12, 8'h34);
    sgn = 1'b1; start = 1'b1; step(); start = 1'b0;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_ready", {31'b0, ready}, 32'd0);
    chk("midreset_product", {16'h0, product}, 32'd0);
    step();
    load8(8'h12, 8'h34);
    run8("after_reset", 1'b1, model(16'h12, 16'h34, 1'b1, 8), 1, 1'b0);

    // Randomized operands and modes.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rx = 8'($urandom); rs = 1'($urandom);
      load8(ra, rx);
      run8($sformatf("rand%0d", i), rs, model({8'h0, ra}, {8'h0, rx}, rs, 8), 1, 1'b0);
    end

    // WIDTH = 16 instance.
    getA16 = 1'b1; in16 = 16'h8000; step();
    getA16 = 1'b0; getX16 = 1'b1; in16 = 16'h7FFF; step();
    getX16 = 1'b0; sgn16 = 1'b1; start16 = 1'b1; step(); start16 = 1'b0;
    lat = 0;
    while (!ready16 && lat < 60) begin step(); lat++; end
    e = model(16'h8000, 16'h7FFF, 1'b1, 16);
    chk("w16_latency", lat, 8);
    chk("w16_product", product16, e);
    chk("w16_product_const", product16, 32'hC0008000);
    getA16 = 1'b1; in16 = 16'hFFFF; step();
    getA16 = 1'b0; getX16 = 1'b1; step();
    getX16 = 1'b0; sgn16 = 1'b0; start16 = 1'b1; step(); start16 = 1'b0;
    lat = 0;
    while (!ready16 && lat < 60) begin step(); lat++; end
    chk("w16_unsigned_latency", lat, 9);
    chk("w16_unsigned_max", product16, model(16'hFFFF, 16'hFFFF, 1'b0, 16));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/radix4_booth_mult_param.md
Name: radix4_booth_mult_param

Overview:
Parametrised radix-4 (modified Booth) sequential multiplier, successor to the fixed 8-bit radix-4 multiplier core.
- Operands are loaded from one shared input bus by getA/getX level strobes; multiplication is launched by a start rising edge.
- Retires one Booth digit per clock. Supports signed and unsigned modes.
- Presents a held 2*WIDTH product with a ready flag, for the board-level display wrapper to consume.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4 (elaboration error otherwise).
- CNT_W, $clog2(WIDTH/2+2), digit counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  launch request; only its rising edge (start & ~start_q) is acted on
- getA  input  1  while high in IDLE, A <= in every clock
- getX  input  1  while high in IDLE, X <= in every clock
- sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled on the accepted start edge
- in  input  WIDTH  shared operand bus
- product  output  2*WIDTH  result, held until the next accepted start
- ready  output  1  product valid
- busy  output  1  high while in CALC

Behaviour:
- Reset (any cycle, including mid-CALC):
  - state = IDLE; A, X, accumulator, counter, start_q all 0.
  - product = 0, ready = 0, busy = 0.
- States:
  - IDLE -> CALC on an accepted start edge.
  - CALC -> IDLE after the last digit.
  - No other transitions.
- IDLE operand loading:
  - getA and getX load on every clock while high; the last sampled value wins.
  - getA and getX high together: both A and X load the same in value.
- Start acceptance:
  - A start edge is accepted only in IDLE with getA = 0 and getX = 0.
  - A start edge coincident with getA/getX is dropped, not queued. The load still happens.
  - On the accepted edge:
    - acc <= 0, counter <= 0;
    - mode <= sgn;
    - multiplier shift register <= {ext, X, 1'b0}, where ext is two copies of X[WIDTH-1] when sgn = 1, else 2'b00;
    - ready <= 0, busy <= 1.
- Digit count N:
  - sgn = 1: N = WIDTH/2.
  - sgn = 0: N = WIDTH/2 + 1 (the extra digit absorbs the zero extension).
- CALC, each cycle:
  - Booth-encode the low 3 bits {x[2i+1], x[2i], x[2i-1]} into a digit in {0, ±1, ±2}.
  - Multiplicand extension: A sign-extended if mode = 1, zero-extended if mode = 0, to 2*WIDTH+2 bits.
  - acc <= acc + (digit*A << 2i), computed modulo 2^(2*WIDTH+2).
  - Shift the multiplier right by 2; increment the counter.
- Completion:
  - On the edge ending CALC cycle N: product <= acc[2*WIDTH-1:0], ready <= 1, busy <= 0, state <= IDLE.
  - Latency: accepted start edge at clock edge E0 -> ready high after edge E0+N.
  - WIDTH = 8: 4 cycles signed, 5 unsigned.
- While busy:
  - start, getA, getX and sgn are ignored.
  - start_q keeps tracking start, so a start held high through completion does not retrigger.
- ready stays high in IDLE, including across operand reloads, until the next accepted start.
- product is never partially updated; it changes only at completion or reset.
- Boundary results (exact, no saturation):
  - A = X = most-negative value in signed mode gives +2^(2*WIDTH-2).
  - Max*max unsigned gives (2^WIDTH-1)^2.

Decomposition:
- Package radix4_mult_pkg:
  - state enum {IDLE, CALC};
  - Booth digit type (3-bit: neg, two, one);
  - localparam helpers for N.
- Sub-module radix4_booth_enc: combinational 3-bit window -> {neg, two, one}.
- The partial-product select and the FSM remain in the top.

Test Plan (WIDTH = 8 unless stated):
- Signed multiply: A = 8'hFB, X = 8'hFF, sgn = 1, start edge -> ready after 4 cycles, product = 16'h0005, busy high exactly 4 cycles.
- Unsigned multiply: same operands with sgn = 0 -> ready after 5 cycles, product = 16'hFA05 (64005).
- Reload then signed: reload X = 8'd8 with getX held 8 cycles (A = 8'hFB), sgn = 1 -> product = 16'hFFD8 (-40). A start held high 6 cycles starts exactly one operation.
- Corner cases:
  - A = X = 8'h80, sgn = 1 -> 16'h4000.
  - A = X = 8'hFF, sgn = 0 -> 16'hFE01.
  - WIDTH = 16: A = 16'h8000, X = 16'h7FFF, signed -> 32'hC0008000, ready after 8 cycles.
- Protocol:
  - getA pulse during CALC leaves A unchanged.
  - Start edge coincident with getX is dropped: state stays IDLE, ready keeps its prior value.
- Reset: rst asserted mid-CALC (cycle 2) -> next cycle IDLE, product = 0, ready = 0, busy = 0; a fresh start then yields the correct result.
